// File: rtl/psram_apb_arbiter.sv
// rtl/psram_apb_arbiter.sv - two-requester round-robin APB arbiter in front of the PSRAM APB port
// Each granted transfer is replayed downstream as SETUP/ACCESS and answered with a one-cycle pready pulse.
module psram_apb_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   in0_paddr,
  input  logic                in0_psel,
  input  logic                in0_penable,
  input  logic [2:0]          in0_pprot,
  input  logic                in0_pwrite,
  input  logic [DATA_W-1:0]   in0_pwdata,
  input  logic [DATA_W/8-1:0] in0_pstrb,
  output logic                in0_pready,
  output logic [DATA_W-1:0]   in0_prdata,
  output logic                in0_pslverr,
  input  logic [ADDR_W-1:0]   in1_paddr,
  input  logic                in1_psel,
  input  logic                in1_penable,
  input  logic [2:0]          in1_pprot,
  input  logic                in1_pwrite,
  input  logic [DATA_W-1:0]   in1_pwdata,
  input  logic [DATA_W/8-1:0] in1_pstrb,
  output logic                in1_pready,
  output logic [DATA_W-1:0]   in1_prdata,
  output logic                in1_pslverr,
  output logic [ADDR_W-1:0]   out_paddr,
  output logic                out_psel,
  output logic                out_penable,
  output logic [2:0]          out_pprot,
  output logic                out_pwrite,
  output logic [DATA_W-1:0]   out_pwdata,
  output logic [DATA_W/8-1:0] out_pstrb,
  input  logic                out_pready,
  input  logic [DATA_W-1:0]   out_prdata,
  input  logic                out_pslverr
);
  localparam int STRB_W = DATA_W / 8;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] out_paddr_q, out_paddr_d;
  logic              out_psel_q, out_psel_d;
  logic              out_penable_q, out_penable_d;
  logic [2:0]        out_pprot_q, out_pprot_d;
  logic              out_pwrite_q, out_pwrite_d;
  logic [DATA_W-1:0] out_pwdata_q, out_pwdata_d;
  logic [STRB_W-1:0] out_pstrb_q, out_pstrb_d;
  logic [1:0]        in_pready_q, in_pready_d;
  logic [1:0]        in_pslverr_q, in_pslverr_d;
  logic [DATA_W-1:0] in0_prdata_q, in0_prdata_d;
  logic [DATA_W-1:0] in1_prdata_q, in1_prdata_d;

  // penable from the requesters carries no information the arbiter needs
  logic unused_penable;
  assign unused_penable = &{1'b0, in0_penable, in1_penable};

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    out_paddr_d   = out_paddr_q;
    out_psel_d    = out_psel_q;
    out_penable_d = out_penable_q;
    out_pprot_d   = out_pprot_q;
    out_pwrite_d  = out_pwrite_q;
    out_pwdata_d  = out_pwdata_q;
    out_pstrb_d   = out_pstrb_q;
    in_pready_d   = 2'b00;
    in_pslverr_d  = 2'b00;
    in0_prdata_d  = '0;
    in1_prdata_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (in0_psel || in1_psel) begin
          // on a tie the requester that did not win last time goes first
          grant_d = (in0_psel && in1_psel) ? ~last_q : in1_psel;
          last_d  = grant_d;
          if (grant_d) begin
            out_paddr_d  = in1_paddr;
            out_pprot_d  = in1_pprot;
            out_pwrite_d = in1_pwrite;
            out_pwdata_d = in1_pwdata;
            out_pstrb_d  = in1_pstrb;
          end else begin
            out_paddr_d  = in0_paddr;
            out_pprot_d  = in0_pprot;
            out_pwrite_d = in0_pwrite;
            out_pwdata_d = in0_pwdata;
            out_pstrb_d  = in0_pstrb;
          end
          out_psel_d    = 1'b1;
          out_penable_d = 1'b0;
          state_d       = ST_SETUP;
        end
      end
      ST_SETUP: begin
        out_penable_d = 1'b1;
        state_d       = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (out_pready) begin
          out_psel_d             = 1'b0;
          out_penable_d          = 1'b0;
          in_pready_d[grant_q]   = 1'b1;
          in_pslverr_d[grant_q]  = out_pslverr;
          if (grant_q) in1_prdata_d = out_prdata;
          else         in0_prdata_d = out_prdata;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      grant_q       <= 1'b0;
      last_q        <= 1'b1;
      out_paddr_q   <= '0;
      out_psel_q    <= 1'b0;
      out_penable_q <= 1'b0;
      out_pprot_q   <= '0;
      out_pwrite_q  <= 1'b0;
      out_pwdata_q  <= '0;
      out_pstrb_q   <= '0;
      in_pready_q   <= 2'b00;
      in_pslverr_q  <= 2'b00;
      in0_prdata_q  <= '0;
      in1_prdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      out_paddr_q   <= out_paddr_d;
      out_psel_q    <= out_psel_d;
      out_penable_q <= out_penable_d;
      out_pprot_q   <= out_pprot_d;
      out_pwrite_q  <= out_pwrite_d;
      out_pwdata_q  <= out_pwdata_d;
      out_pstrb_q   <= out_pstrb_d;
      in_pready_q   <= in_pready_d;
      in_pslverr_q  <= in_pslverr_d;
      in0_prdata_q  <= in0_prdata_d;
      in1_prdata_q  <= in1_prdata_d;
    end
  end

  assign out_paddr   = out_paddr_q;
  assign out_psel    = out_psel_q;
  assign out_penable = out_penable_q;
  assign out_pprot   = out_pprot_q;
  assign out_pwrite  = out_pwrite_q;
  assign out_pwdata  = out_pwdata_q;
  assign out_pstrb   = out_pstrb_q;
  assign in0_pready  = in_pready_q[0];
  assign in1_pready  = in_pready_q[1];
  assign in0_pslverr = in_pslverr_q[0];
  assign in1_pslverr = in_pslverr_q[1];
  assign in0_prdata  = in0_prdata_q;
  assign in1_prdata  = in1_prdata_q;

endmodule
